// File: rtl/alu_wb_queue_pkg.sv
// alu_wb_queue_pkg: shared widths, drain state encoding and queue entry layouts.
package alu_wb_queue_pkg;
    localparam int LEN_DATA = 64;
    localparam int REG_ADDR_W = 5;
    localparam int TAG_W = REG_ADDR_W + 1;
    localparam int RES_W = REG_ADDR_W + 1 + 2 * LEN_DATA + 1;

    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } drain_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  ex;
    } tag_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  ex;
        logic [LEN_DATA-1:0]   result;
        logic [LEN_DATA-1:0]   ex_result;
        logic                  cout;
    } res_t;
endpackage

// File: rtl/alu_wb_queue_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; push at full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_wb_queue.sv
// alu_wb_queue: pairs ALU results with in-order destination tags and drains them
// to the register-file write port, splitting extended results into two beats.
module alu_wb_queue
    import alu_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [REG_ADDR_W-1:0]   iss_rd,
    input  logic                    iss_ex,
    output logic                    iss_ready,
    input  logic                    alu_rdy,
    input  logic [LEN_DATA-1:0]     alu_result,
    input  logic [LEN_DATA-1:0]     alu_ex_result,
    input  logic                    alu_cout,
    output logic                    wb_valid,
    output logic [REG_ADDR_W-1:0]   wb_rd,
    output logic [LEN_DATA-1:0]     wb_data,
    output logic                    wb_cout,
    input  logic                    wb_ready,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  inflight
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAX_CREDITS = CW'(DEPTH);

    drain_t st, st_n;
    tag_t   tag_in, tag_head;
    res_t   res_in, res_head;
    logic   tag_full, tag_empty, res_full, res_empty;
    logic   acc, res_push, res_pop, hs;

    assign iss_ready = inflight < MAX_CREDITS;
    assign acc       = iss_valid & iss_ready & !tag_full;
    assign tag_in    = '{rd: iss_rd, ex: iss_ex};
    assign hs        = wb_valid & wb_ready;
    assign res_pop   = hs & (st == BEAT1 | !res_head.ex);
    assign res_push  = alu_rdy & !tag_empty & (!res_full | res_pop);
    assign res_in    = '{rd: tag_head.rd, ex: tag_head.ex, result: alu_result,
                         ex_result: alu_ex_result, cout: alu_cout};

    sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_q (
        .clk(clk), .rst(rst), .push(acc), .pop(res_push), .din(tag_in),
        .head(tag_head), .full(tag_full), .empty(tag_empty)
    );

    sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_q (
        .clk(clk), .rst(rst), .push(res_push), .pop(res_pop), .din(res_in),
        .head(res_head), .full(res_full), .empty(res_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= BEAT0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            st       <= st_n;
            inflight <= inflight + CW'(acc) - CW'(res_pop);
            err      <= err | (iss_valid & !iss_ready) | (alu_rdy & tag_empty);
        end
    end

    // Outputs are forced to zero when idle so the port looks like reset between bursts.
    always_comb begin
        st_n     = hs ? ((st == BEAT0 && res_head.ex) ? BEAT1 : BEAT0) : st;
        wb_valid = !res_empty;
        wb_rd    = !wb_valid ? '0 : (st == BEAT1 ? res_head.rd + 1'b1 : res_head.rd);
        wb_data  = !wb_valid ? '0 : (st == BEAT1 ? res_head.ex_result : res_head.result);
        wb_cout  = wb_valid & (st == BEAT0) & res_head.cout;
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// tb_alu_wb_queue: random and directed stimulus checked against a beat-stream reference model.
module tb_alu_wb_queue;
    import alu_wb_queue_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, iss_valid, iss_ex, iss_ready, alu_rdy, alu_cout;
    logic wb_valid, wb_cout, wb_ready, err;
    logic [4:0]  iss_rd, wb_rd;
    logic [63:0] alu_result, alu_ex_result, wb_data;
    logic [2:0]  inflight;

    always #5 clk = ~clk;

    alu_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ex(iss_ex),
        .iss_ready(iss_ready), .alu_rdy(alu_rdy), .alu_result(alu_result),
        .alu_ex_result(alu_ex_result), .alu_cout(alu_cout), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_cout(wb_cout), .wb_ready(wb_ready),
        .err(err), .inflight(inflight)
    );

    typedef struct { logic [4:0] rd; logic [63:0] data; logic cout; bit last; } beat_t;
    typedef struct { logic [4:0] rd; bit ex; } mtag_t;

    beat_t mbeats[$];
    mtag_t mtags[$];
    int credits;
    bit merr;
    int n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: every accepted op becomes one or two expected write beats, in order.
    task automatic model_step();
        bit ready, hs, last;
        mtag_t t;
        if (rst) begin
            mbeats.delete();
            mtags.delete();
            credits = 0;
            merr = 0;
            return;
        end
        ready = credits < DEPTH;
        hs = mbeats.size() > 0 && wb_ready;
        last = 0;
        if (hs) begin
            last = mbeats[0].last;
            void'(mbeats.pop_front());
        end
        if (iss_valid && !ready) merr = 1;
        if (alu_rdy) begin
            if (mtags.size() == 0) merr = 1;
            else begin
                t = mtags.pop_front();
                mbeats.push_back('{t.rd, alu_result, alu_cout, !t.ex});
                if (t.ex) mbeats.push_back('{5'((int'(t.rd) + 1) % 32), alu_ex_result, 1'b0, 1'b1});
            end
        end
        if (iss_valid && ready) mtags.push_back('{iss_rd, iss_ex});
        credits = credits + int'(iss_valid && ready) - int'(last);
    endtask

    task automatic compare();
        check("wb_valid", wb_valid, 64'(mbeats.size() > 0));
        if (mbeats.size() > 0) begin
            check("wb_rd", wb_rd, mbeats[0].rd);
            check("wb_data", wb_data, mbeats[0].data);
            check("wb_cout", wb_cout, mbeats[0].cout);
        end
        check("iss_ready", iss_ready, 64'(credits < DEPTH));
        check("inflight", inflight, 64'(credits));
        check("err", err, merr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        iss_valid = 0; alu_rdy = 0; rst = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ex);
        iss_valid = 1; iss_rd = rd; iss_ex = ex;
    endtask

    task automatic rdy(input logic [63:0] r, input logic [63:0] x, input logic c);
        alu_rdy = 1; alu_result = r; alu_ex_result = x; alu_cout = c;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic drain();
        idle();
        wb_ready = 1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0; credits = 0; merr = 0;
        rst = 1; iss_valid = 0; iss_rd = 0; iss_ex = 0; alu_rdy = 0;
        alu_result = 0; alu_ex_result = 0; alu_cout = 0; wb_ready = 0;
        @(negedge clk);
        tick();
        rst = 0;
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_cout", wb_cout, 0);
        check("rst_iss_ready", iss_ready, 1);

        // Single non-ex op
        wb_ready = 1;
        issue(3, 0); tick();
        idle(); tick();
        rdy(64'h1234, 64'h0, 1); tick();
        idle();
        check("t1_valid", wb_valid, 1);
        check("t1_rd", wb_rd, 3);
        check("t1_data", wb_data, 64'h1234);
        check("t1_cout", wb_cout, 1);
        tick();
        check("t1_inflight", inflight, 0);
        check("t1_idle", wb_valid, 0);

        // Ex op with register wrap
        issue(31, 1); tick();
        idle(); rdy(64'hAAAA_0001, 64'hBBBB_0002, 1); tick();
        idle();
        check("t2_rd0", wb_rd, 31);
        check("t2_data0", wb_data, 64'hAAAA_0001);
        tick();
        check("t2_rd1", wb_rd, 0);
        check("t2_data1", wb_data, 64'hBBBB_0002);
        check("t2_cout1", wb_cout, 0);
        tick();
        check("t2_inflight", inflight, 0);

        // Fill all credits with the write port stalled
        wb_ready = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            issue(5'(10 + i), 1'(i % 2));
            if (i > 0) rdy(64'(100 + i), 64'(200 + i), 1'(i % 2));
            tick();
        end
        check("t3_full_ready", iss_ready, 0);
        check("t3_held_rd", wb_rd, 10);
        idle(); rdy(64'(104), 64'(204), 0); issue(20, 0); tick();
        check("t3_err", err, 1);
        check("t3_held_data", wb_data, 64'd101);
        idle(); wb_ready = 1; tick();
        check("t3_ready_rise", iss_ready, 1);
        drain();
        do_reset();

        // Back-to-back non-ex ops
        wb_ready = 1;
        issue(1, 0); tick();
        for (int i = 0; i < 20; i++) begin
            idle();
            issue(5'($urandom), 0);
            rdy({$urandom, $urandom}, 64'h0, 1'($urandom));
            tick();
            if (i >= 1) begin
                check("t4_inflight", inflight, 2);
                check("t4_valid", wb_valid, 1);
            end
        end
        idle(); rdy(64'h5, 64'h0, 0); tick();
        drain();
        check("t4_err", err, 0);

        // alu_rdy with nothing outstanding
        idle(); rdy(64'h77, 64'h0, 1); tick();
        idle();
        check("t5_err", err, 1);
        check("t5_valid", wb_valid, 0);
        tick();

        // Reset during the second beat of an ex op
        do_reset();
        issue(7, 1); tick();
        idle(); rdy(64'h11, 64'h22, 1); tick();
        idle(); wb_ready = 1; tick();
        check("t6_in_beat1", wb_rd, 8);
        wb_ready = 0; rst = 1; tick();
        rst = 0;
        check("t6_valid", wb_valid, 0);
        check("t6_inflight", inflight, 0);
        check("t6_err", err, 0);
        issue(9, 0); tick();
        idle(); rdy(64'h99, 64'h0, 0); tick();
        idle(); wb_ready = 1;
        check("t6_new_rd", wb_rd, 9);
        check("t6_new_data", wb_data, 64'h99);
        tick();

        // Randomized legal traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            wb_ready = $urandom_range(0, 3) != 0;
            if (credits < DEPTH && $urandom_range(0, 1) == 1) issue(5'($urandom), 1'($urandom));
            if (mtags.size() > 0 && $urandom_range(0, 1) == 1)
                rdy({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            tick();
        end
        while (mtags.size() > 0) begin
            idle(); rdy({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom)); tick();
        end
        drain();
        check("rand_drained", inflight, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
